// File: rtl/seg_display_driver_if.sv
// seg_display_driver_if: status inputs (mode, value) and multiplexed
// 7-segment outputs of seg_display_driver.
// master = producer of status / consumer of display lines; slave = driver.
interface seg_display_driver_if;
   logic [4:0]  display_model;
   logic [15:0] display_number;
   logic [5:0]  seg_sel;
   logic [7:0]  seg_data;
   logic        conv_busy;

   modport master (
      output display_model, display_number,
      input  seg_sel, seg_data, conv_busy
   );

   modport slave (
      input  display_model, display_number,
      output seg_sel, seg_data, conv_busy
   );
endinterface

// File: rtl/seg_display_driver.sv
// seg_display_driver: converts a 16-bit value to 5 BCD digits with a
// sequential double-dabble engine and scans a 6-digit common-anode display.
// Digit 5 shows the mode number with its dp lit; digits 4..0 show the value.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (blank leading zeros of
// value digits 4..1).
module seg_display_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input logic              mem_clk,
   input logic              rst,
   seg_display_driver_if.slave bus
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] LIT_END = CW'(SCAN_DIV - BLANK_CYC);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t        state_q, state_d;
   logic [20:0]   cap_q, cap_d;            // {model, number} last captured
   logic [19:0]   work_q, work_d;          // BCD accumulator
   logic [15:0]   sh_q, sh_d;              // binary shift register
   logic [3:0]    bit_q, bit_d;            // shift step counter
   logic          busy_q, busy_d;
   logic [19:0]   shown_bcd_q, shown_bcd_d;
   logic [4:0]    shown_model_q, shown_model_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [5:0]    sel_q, sel_d;
   logic [7:0]    data_q, data_d;

   logic [19:0]   adj;
   logic [3:0]    cur_nib;
   logic          lead_zero;

   function automatic logic [7:0] font(input logic [3:0] v);
      case (v)
         4'd0:    font = 8'hC0;
         4'd1:    font = 8'hF9;
         4'd2:    font = 8'hA4;
         4'd3:    font = 8'hB0;
         4'd4:    font = 8'h99;
         4'd5:    font = 8'h92;
         4'd6:    font = 8'h82;
         4'd7:    font = 8'hF8;
         4'd8:    font = 8'h80;
         4'd9:    font = 8'h90;
         default: font = 8'hFF;
      endcase
   endfunction

   // Double-dabble correction: add 3 to every nibble that is 5 or more
   always_comb begin
      adj = work_q;
      for (int i = 0; i < 5; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

   // Converter next-state: capture on change, 16 shift steps, then publish
   always_comb begin
      state_d       = state_q;
      cap_d         = cap_q;
      work_d        = work_q;
      sh_d          = sh_q;
      bit_d         = bit_q;
      busy_d        = busy_q;
      shown_bcd_d   = shown_bcd_q;
      shown_model_d = shown_model_q;
      case (state_q)
         IDLE: begin
            if ({bus.display_model, bus.display_number} != cap_q) begin
               cap_d   = {bus.display_model, bus.display_number};
               work_d  = '0;
               sh_d    = bus.display_number;
               bit_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = {adj[18:0], sh_q[15]};
            sh_d   = {sh_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) state_d = COMMIT;
         end
         COMMIT: begin
            // Shown registers move only here, never mid-conversion
            shown_bcd_d   = work_q;
            shown_model_d = cap_q[20:16];
            busy_d        = 1'b0;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan timing: slot counter, digit index, and digit enables
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      sel_d = (cnt_q < LIT_END) ? ~(6'd1 << idx_q) : 6'h3F;
   end

   // Segment pattern for the digit currently being scanned
   always_comb begin
      case (idx_q)
         3'd0:    cur_nib = shown_bcd_q[3:0];
         3'd1:    cur_nib = shown_bcd_q[7:4];
         3'd2:    cur_nib = shown_bcd_q[11:8];
         3'd3:    cur_nib = shown_bcd_q[15:12];
         default: cur_nib = shown_bcd_q[19:16];
      endcase
      // This digit and everything to its left is zero
      lead_zero = (idx_q != 3'd0) && ((shown_bcd_q >> {idx_q, 2'b00}) == 20'd0);
      data_d = font(cur_nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (lead_zero) data_d = 8'hFF;
`endif
      if (idx_q == 3'd5)
         data_d = ((shown_model_q <= 5'd9) ? font(shown_model_q[3:0]) : 8'h86) & 8'h7F;
   end

   // State registers
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cap_q         <= '0;
         work_q        <= '0;
         sh_q          <= '0;
         bit_q         <= '0;
         busy_q        <= 1'b0;
         shown_bcd_q   <= '0;
         shown_model_q <= '0;
         cnt_q         <= '0;
         idx_q         <= '0;
         sel_q         <= 6'h3F;
         data_q        <= 8'hFF;
      end else begin
         state_q       <= state_d;
         cap_q         <= cap_d;
         work_q        <= work_d;
         sh_q          <= sh_d;
         bit_q         <= bit_d;
         busy_q        <= busy_d;
         shown_bcd_q   <= shown_bcd_d;
         shown_model_q <= shown_model_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         sel_q         <= sel_d;
         data_q        <= data_d;
      end
   end

   assign bus.seg_sel   = sel_q;
   assign bus.seg_data  = data_q;
   assign bus.conv_busy = busy_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_display_driver;

   logic mem_clk = 1'b0;
   logic rst     = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   seg_display_driver_if bus();

   seg_display_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .mem_clk (mem_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 mem_clk = ~mem_clk;

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] Z = 8'hFF;  // leading zero glyph
`else
   localparam logic [7:0] Z = 8'hC0;
`endif

   // Wait (bounded) until digit k is enabled, return its segment pattern
   task automatic read_digit(input int k, output logic [7:0] d, output bit ok);
      logic [5:0] want;
      want = ~(6'd1 << k);
      ok = 1'b0;
      d  = 8'h00;
      for (int i = 0; i < 100; i++) begin
         @(negedge mem_clk);
         if (bus.seg_sel === want) begin
            d  = bus.seg_data;
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Count consecutive busy-high samples until busy is seen low (bounded)
   task automatic wait_idle(output int hi, output bit ok);
      hi = 0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge mem_clk);
         if (bus.conv_busy === 1'b1) hi++;
         else begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit seen_busy;
      bus.display_model  = 5'd0;
      bus.display_number = 16'd0;
      rst = 1'b1;
      repeat (3) @(negedge mem_clk);
      checks++;
      if (bus.seg_sel !== 6'h3F) begin
         errors++; $display("FAIL reset_sel got %h want 3f", bus.seg_sel);
      end
      checks++;
      if (bus.seg_data !== 8'hFF) begin
         errors++; $display("FAIL reset_data got %h want ff", bus.seg_data);
      end
      checks++;
      if (bus.conv_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", bus.conv_busy);
      end
      rst = 1'b0;
      @(negedge mem_clk);
      checks++;
      if (bus.seg_sel !== 6'h3E) begin
         errors++; $display("FAIL first_sel got %h want 3e", bus.seg_sel);
      end
      checks++;
      if (bus.seg_data !== 8'hC0) begin
         errors++; $display("FAIL first_data got %h want c0", bus.seg_data);
      end
      seen_busy = 1'b0;
      repeat (20) begin
         @(negedge mem_clk);
         if (bus.conv_busy !== 1'b0) seen_busy = 1'b1;
      end
      checks++;
      if (seen_busy) begin
         errors++; $display("FAIL idle_no_conv got busy=1 want busy=0");
      end
   endtask

   task automatic test_convert();
      logic [7:0] exp [6];
      logic [7:0] d;
      int hi;
      bit ok;
      exp = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h79};
      bus.display_model  = 5'd1;
      bus.display_number = 16'd12345;
      wait_idle(hi, ok);
      checks++;
      if (!ok || hi != 17) begin
         errors++; $display("FAIL conv_busy_len got %0d (ok=%0b) want 17", hi, ok);
      end
      for (int k = 0; k < 6; k++) begin
         read_digit(k, d, ok);
         checks++;
         if (!ok || d !== exp[k]) begin
            errors++; $display("FAIL conv_digit%0d got %h (ok=%0b) want %h", k, d, ok, exp[k]);
         end
      end
   endtask

   task automatic test_scan();
      logic [5:0] prev, want;
      bit found;
      found = 1'b0;
      prev  = bus.seg_sel;
      for (int i = 0; i < 100; i++) begin
         @(negedge mem_clk);
         if (prev === 6'h3F && bus.seg_sel === 6'h3E) begin
            found = 1'b1;
            break;
         end
         prev = bus.seg_sel;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL scan_sync got none want slot0 start");
      end
      for (int t = 0; t < 48; t++) begin
         if (t != 0) @(negedge mem_clk);
         want = ((t % 8) < 6) ? ~(6'd1 << (t / 8)) : 6'h3F;
         checks++;
         if (bus.seg_sel !== want) begin
            errors++; $display("FAIL scan_t%0d got %h want %h", t, bus.seg_sel, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [6];
      logic [7:0] d;
      int hi;
      bit ok;
      exp = '{8'hF8, Z, Z, Z, Z, 8'h79};
      bus.display_number = 16'd65535;
      repeat (4) @(negedge mem_clk);
      bus.display_number = 16'd7;       // lands during SHIFT
      wait_idle(hi, ok);
      checks++;
      if (!ok || hi != 13) begin
         errors++; $display("FAIL b2b_first_len got %0d (ok=%0b) want 13", hi, ok);
      end
      @(negedge mem_clk);
      checks++;
      if (bus.conv_busy !== 1'b1) begin
         errors++; $display("FAIL b2b_restart got %b want 1", bus.conv_busy);
      end
      wait_idle(hi, ok);
      checks++;
      if (!ok || hi != 16) begin
         errors++; $display("FAIL b2b_second_len got %0d (ok=%0b) want 16", hi, ok);
      end
      for (int k = 0; k < 6; k++) begin
         read_digit(k, d, ok);
         checks++;
         if (!ok || d !== exp[k]) begin
            errors++; $display("FAIL b2b_digit%0d got %h (ok=%0b) want %h", k, d, ok, exp[k]);
         end
      end
   endtask

   task automatic test_max();
      logic [7:0] exp [6];
      logic [7:0] d;
      int hi;
      bit ok;
      exp = '{8'h92, 8'hB0, 8'h92, 8'h92, 8'h82, 8'h79};
      bus.display_number = 16'd65535;
      wait_idle(hi, ok);
      checks++;
      if (!ok || hi != 17) begin
         errors++; $display("FAIL max_busy_len got %0d (ok=%0b) want 17", hi, ok);
      end
      for (int k = 0; k < 6; k++) begin
         read_digit(k, d, ok);
         checks++;
         if (!ok || d !== exp[k]) begin
            errors++; $display("FAIL max_digit%0d got %h (ok=%0b) want %h", k, d, ok, exp[k]);
         end
      end
   endtask

   task automatic test_model_err();
      logic [7:0] d;
      int hi;
      bit ok;
      bus.display_model = 5'd12;
      wait_idle(hi, ok);
      read_digit(5, d, ok);
      checks++;
      if (!ok || d !== 8'h06) begin
         errors++; $display("FAIL err_digit5 got %h (ok=%0b) want 06", d, ok);
      end
      read_digit(0, d, ok);
      checks++;
      if (!ok || d !== 8'h92) begin
         errors++; $display("FAIL err_digit0 got %h (ok=%0b) want 92", d, ok);
      end
      read_digit(4, d, ok);
      checks++;
      if (!ok || d !== 8'h82) begin
         errors++; $display("FAIL err_digit4 got %h (ok=%0b) want 82", d, ok);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [6];
      logic [7:0] d;
      int hi;
      bit ok;
      exp = '{8'h90, 8'h90, 8'h90, Z, Z, 8'h24};
      bus.display_model  = 5'd2;
      bus.display_number = 16'd999;
      repeat (6) @(negedge mem_clk);
      checks++;
      if (bus.conv_busy !== 1'b1) begin
         errors++; $display("FAIL mid_busy got %b want 1", bus.conv_busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.seg_sel !== 6'h3F || bus.seg_data !== 8'hFF || bus.conv_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got sel=%h data=%h busy=%b want 3f ff 0",
                  bus.seg_sel, bus.seg_data, bus.conv_busy);
      end
      repeat (2) @(negedge mem_clk);
      rst = 1'b0;
      wait_idle(hi, ok);
      checks++;
      if (!ok || hi != 17) begin
         errors++; $display("FAIL mid_restart_len got %0d (ok=%0b) want 17", hi, ok);
      end
      for (int k = 0; k < 6; k++) begin
         read_digit(k, d, ok);
         checks++;
         if (!ok || d !== exp[k]) begin
            errors++; $display("FAIL mid_digit%0d got %h (ok=%0b) want %h", k, d, ok, exp[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_scan();
      test_back_to_back();
      test_max();
      test_model_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
